// File: rtl/pcsp_mem_sequencer.sv
// pcsp_mem_sequencer
//   Multicycle control FSM for the PC/SP/memory datapath. It fetches an
//   instruction, latches its opcode, then drives the datapath selects and
//   write enables for the execute, memory and writeback steps. Each memory
//   access (fetch or data) lasts MEM_WAIT extra cycles before its final
//   cycle. The block also keeps a sticky illegal-opcode flag and a count of
//   retired instructions.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start             leave IDLE/HALT and begin fetching at the current PC
//   inst[15:0]        instruction register contents, opcode = inst[15:12]
//   comp_taken        branch condition, used by BR in EXEC
//   PCSrc, SPSrc      PC / SP next-value selects
//   SPWrite, PCWrite  SP / PC register enables
//   InstWrite         instruction register enable
//   MemWrite          memory write strobe, one pulse per store
//   MemSrc, MemDst    memory address select / write-data select
//   RegWrite          register-file write of the loaded value
//   LinkWrite         write PC into RA (JAL)
//   busy, halted      status: running / sitting in HALT
//   error             sticky illegal-opcode flag, cleared only by reset
//   instr_count       retired instructions, wraps modulo 2^CNT_W
//   state_dbg         current FSM state (IDLE=0 FETCH=1 DECODE=2 EXEC=3
//                     MEM=4 WB=5 HALT=6)
//
// Handshake: start is a level request sampled only while busy=0 (IDLE or
// HALT); the FSM accepts it on the same rising edge and busy rises in the
// following cycle. While busy=1, start is ignored.
module pcsp_mem_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      inst,
  input  logic             comp_taken,
  output logic [2:0]       PCSrc,
  output logic [2:0]       SPSrc,
  output logic             SPWrite,
  output logic             PCWrite,
  output logic             InstWrite,
  output logic             MemWrite,
  output logic [1:0]       MemSrc,
  output logic [2:0]       MemDst,
  output logic             RegWrite,
  output logic             LinkWrite,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_PUSH = 4'd3;
  localparam logic [3:0] OP_POP  = 4'd4;
  localparam logic [3:0] OP_J    = 4'd5;
  localparam logic [3:0] OP_JAL  = 4'd6;
  localparam logic [3:0] OP_JR   = 4'd7;
  localparam logic [3:0] OP_BR   = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd15;

  // Value of the wait counter on the final cycle of a memory access.
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t           state;
  state_t           state_next;
  logic [3:0]       opcode;
  logic [2:0]       wait_cnt;
  logic             error_q;
  logic [CNT_W-1:0] count_q;

  logic             mem_last;
  logic             wait_adv;
  logic             retire;
  logic             set_error;

  // Raw enables before reset gating.
  logic             sp_we;
  logic             pc_we;
  logic             inst_we;
  logic             mem_we;
  logic             reg_we;
  logic             link_we;

  // Only the opcode field of the instruction matters here.
  logic             unused_inst_bits;
  assign unused_inst_bits = ^inst[11:0];

  assign mem_last = (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    wait_adv   = 1'b0;
    retire     = 1'b0;
    set_error  = 1'b0;
    PCSrc      = 3'd0;
    SPSrc      = 3'd0;
    MemSrc     = 2'd0;
    MemDst     = 3'd0;
    sp_we      = 1'b0;
    pc_we      = 1'b0;
    inst_we    = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    link_we    = 1'b0;

    case (state)
      S_IDLE, S_HALT: begin
        if (start) state_next = S_FETCH;
      end

      S_FETCH: begin
        // MemSrc stays 0 (PC) for every fetch cycle.
        if (mem_last) begin
          inst_we    = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end else begin
          wait_adv = 1'b1;
        end
      end

      S_DECODE: begin
        state_next = S_EXEC;
      end

      S_EXEC: begin
        case (opcode)
          OP_ALU: begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_LW, OP_SW, OP_POP: begin
            state_next = S_MEM;
          end
          OP_PUSH: begin
            // Pre-decrement SP so MEM writes to the new top of stack.
            sp_we      = 1'b1;
            SPSrc      = 3'd1;
            state_next = S_MEM;
          end
          OP_J: begin
            pc_we      = 1'b1;
            PCSrc      = 3'd1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_JAL: begin
            link_we    = 1'b1;
            pc_we      = 1'b1;
            PCSrc      = 3'd1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_JR: begin
            pc_we      = 1'b1;
            PCSrc      = 3'd2;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_BR: begin
            pc_we      = comp_taken;
            PCSrc      = 3'd4;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          OP_HALT: begin
            retire     = 1'b1;
            state_next = S_HALT;
          end
          default: begin
            // Opcodes 9..14 are illegal: stop without retiring.
            set_error  = 1'b1;
            state_next = S_HALT;
          end
        endcase
      end

      S_MEM: begin
        case (opcode)
          OP_LW:   MemSrc = 2'd2;
          OP_SW:   MemSrc = 2'd3;
          default: MemSrc = 2'd1;
        endcase
        if (opcode == OP_PUSH) MemDst = 3'd1;
        if (mem_last) begin
          if (opcode == OP_SW || opcode == OP_PUSH) begin
            mem_we     = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else begin
          wait_adv = 1'b1;
        end
      end

      S_WB: begin
        reg_we = 1'b1;
        if (opcode == OP_POP) begin
          // Post-increment SP after the pop has been read.
          sp_we = 1'b1;
          SPSrc = 3'd2;
        end
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Enables are forced low in the reset cycle so a store (or any register
  // update) that would coincide with reset never reaches the datapath.
  assign SPWrite   = sp_we   & ~reset;
  assign PCWrite   = pc_we   & ~reset;
  assign InstWrite = inst_we & ~reset;
  assign MemWrite  = mem_we  & ~reset;
  assign RegWrite  = reg_we  & ~reset;
  assign LinkWrite = link_we & ~reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      opcode   <= 4'd0;
      wait_cnt <= 3'd0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) opcode <= inst[15:12];
      // Counter returns to 0 on every final access cycle and in every
      // non-access state, so it is always 0 on entry to FETCH or MEM.
      wait_cnt <= wait_adv ? (wait_cnt + 3'd1) : 3'd0;
      if (set_error) error_q <= 1'b1;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign halted      = (state == S_HALT);
  assign error       = error_q;
  assign instr_count = count_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_pcsp_mem_sequencer.sv
// Directed testbench for pcsp_mem_sequencer. Two instances are used:
// dut_a with MEM_WAIT=0 and dut_b with MEM_WAIT=2. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_pcsp_mem_sequencer;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // Packs a control word: {PCSrc, SPSrc, SPWrite, PCWrite, InstWrite,
  // MemWrite, MemSrc, MemDst, RegWrite, LinkWrite}.
  function automatic logic [16:0] cw(input logic [2:0] pcs, input logic [2:0] sps,
                                     input logic spw, input logic pcw, input logic iw,
                                     input logic mw, input logic [1:0] ms,
                                     input logic [2:0] md, input logic rw, input logic lw);
    return {pcs, sps, spw, pcw, iw, mw, ms, md, rw, lw};
  endfunction

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, rst_b, start_b, comp_taken;
  logic [15:0] inst_a, inst_b;

  // dut_a outputs
  logic [2:0]  a_pcsrc, a_spsrc, a_memdst, a_st;
  logic [1:0]  a_memsrc;
  logic        a_spw, a_pcw, a_iw, a_mw, a_rw, a_lw, a_busy, a_halted, a_error;
  logic [15:0] a_count;
  // dut_b outputs
  logic [2:0]  b_pcsrc, b_spsrc, b_memdst, b_st;
  logic [1:0]  b_memsrc;
  logic        b_spw, b_pcw, b_iw, b_mw, b_rw, b_lw, b_busy, b_halted, b_error;
  logic [15:0] b_count;

  logic [16:0] ctl_a, ctl_b;
  assign ctl_a = {a_pcsrc, a_spsrc, a_spw, a_pcw, a_iw, a_mw, a_memsrc, a_memdst, a_rw, a_lw};
  assign ctl_b = {b_pcsrc, b_spsrc, b_spw, b_pcw, b_iw, b_mw, b_memsrc, b_memdst, b_rw, b_lw};

  pcsp_mem_sequencer #(.MEM_WAIT(0), .CNT_W(16)) dut_a (
    .clock(clk), .reset(rst_a), .start(start_a), .inst(inst_a), .comp_taken(comp_taken),
    .PCSrc(a_pcsrc), .SPSrc(a_spsrc), .SPWrite(a_spw), .PCWrite(a_pcw),
    .InstWrite(a_iw), .MemWrite(a_mw), .MemSrc(a_memsrc), .MemDst(a_memdst),
    .RegWrite(a_rw), .LinkWrite(a_lw), .busy(a_busy), .halted(a_halted),
    .error(a_error), .instr_count(a_count), .state_dbg(a_st)
  );

  pcsp_mem_sequencer #(.MEM_WAIT(2), .CNT_W(16)) dut_b (
    .clock(clk), .reset(rst_b), .start(start_b), .inst(inst_b), .comp_taken(comp_taken),
    .PCSrc(b_pcsrc), .SPSrc(b_spsrc), .SPWrite(b_spw), .PCWrite(b_pcw),
    .InstWrite(b_iw), .MemWrite(b_mw), .MemSrc(b_memsrc), .MemDst(b_memdst),
    .RegWrite(b_rw), .LinkWrite(b_lw), .busy(b_busy), .halted(b_halted),
    .error(b_error), .instr_count(b_count), .state_dbg(b_st)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] CW_FETCH;
  initial CW_FETCH = cw(3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);

  // ---------------- driver tasks ----------------
  // Reset, then start with the given instruction; returns at the falling
  // edge of the first FETCH cycle with start already released.
  task automatic begin_a(input logic [15:0] ins);
    rst_a = 1'b1; start_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b0; inst_a = ins; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic begin_b(input logic [15:0] ins);
    rst_b = 1'b1; start_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b0; inst_b = ins; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    inst_a = 16'h0000; inst_b = 16'h0000; comp_taken = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_st !== ST_IDLE || ctl_a !== 17'd0 || a_count !== 16'd0 || a_error !== 1'b0 ||
        a_busy !== 1'b0 || a_halted !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_a: state=%0d ctl=%h cnt=%0d err=%b busy=%b halt=%b, want 0 0 0 0 0 0",
               a_st, ctl_a, a_count, a_error, a_busy, a_halted);
    end
    n_cmp++;
    if (b_st !== ST_IDLE || ctl_b !== 17'd0 || b_count !== 16'd0 || b_error !== 1'b0 ||
        b_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_b: state=%0d ctl=%h cnt=%0d err=%b busy=%b, want 0 0 0 0 0",
               b_st, ctl_b, b_count, b_error, b_busy);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_st !== ST_IDLE) begin
      n_bad++;
      $display("FAIL idle_hold: state=%0d, want %0d", a_st, ST_IDLE);
    end
  endtask

  task automatic test_alu_loop();
    logic [2:0]  exp_st[3];
    logic [16:0] exp_ctl[3];
    int pcw_pulses;
    exp_st[0] = ST_FETCH; exp_st[1] = ST_DECODE; exp_st[2] = ST_EXEC;
    exp_ctl[0] = CW_FETCH; exp_ctl[1] = 17'd0; exp_ctl[2] = 17'd0;
    pcw_pulses = 0;
    begin_a(16'h0000);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      if (a_pcw === 1'b1) pcw_pulses++;
      n_cmp++;
      if (a_st !== exp_st[i % 3] || ctl_a !== exp_ctl[i % 3]) begin
        n_bad++;
        $display("FAIL alu c%0d: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i + 1, a_st, ctl_a, exp_st[i % 3], exp_ctl[i % 3]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (a_count !== 16'd3 || pcw_pulses != 3 || a_st !== ST_FETCH) begin
      n_bad++;
      $display("FAIL alu_count: cnt=%0d pcw_pulses=%0d state=%0d, want 3 3 %0d",
               a_count, pcw_pulses, a_st, ST_FETCH);
    end
  endtask

  task automatic test_push_pop();
    logic [2:0]  exp_st[10];
    logic [16:0] exp_ctl[10];
    int mw_pulses;
    exp_st = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_FETCH,
               ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_FETCH};
    exp_ctl[0] = CW_FETCH;
    exp_ctl[1] = 17'd0;
    exp_ctl[2] = cw(3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    exp_ctl[3] = cw(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b0);
    exp_ctl[4] = CW_FETCH;
    exp_ctl[5] = 17'd0;
    exp_ctl[6] = 17'd0;
    exp_ctl[7] = cw(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0);
    exp_ctl[8] = cw(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
    exp_ctl[9] = CW_FETCH;
    mw_pulses = 0;
    begin_a(16'h3000);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 2) inst_a = 16'h4000;  // PUSH opcode already latched
      if (a_mw === 1'b1) mw_pulses++;
      n_cmp++;
      if (a_st !== exp_st[i] || ctl_a !== exp_ctl[i]) begin
        n_bad++;
        $display("FAIL push_pop c%0d: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i + 1, a_st, ctl_a, exp_st[i], exp_ctl[i]);
      end
      if (i == 4) begin
        n_cmp++;
        if (a_count !== 16'd1) begin
          n_bad++;
          $display("FAIL push_retire: cnt=%0d, want 1", a_count);
        end
      end
    end
    n_cmp++;
    if (a_count !== 16'd2 || mw_pulses != 1) begin
      n_bad++;
      $display("FAIL pop_retire: cnt=%0d memwrite_pulses=%0d, want 2 1", a_count, mw_pulses);
    end
  endtask

  task automatic test_sw_wait();
    logic [2:0]  exp_st[11];
    logic [16:0] exp_ctl[11];
    logic [16:0] cw_mem;
    cw_mem = cw(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b0, 1'b0);
    exp_st = '{ST_FETCH, ST_FETCH, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM,
               ST_MEM, ST_MEM, ST_FETCH, ST_FETCH, ST_FETCH};
    exp_ctl[0]  = 17'd0;
    exp_ctl[1]  = 17'd0;
    exp_ctl[2]  = CW_FETCH;
    exp_ctl[3]  = 17'd0;
    exp_ctl[4]  = 17'd0;
    exp_ctl[5]  = cw_mem;
    exp_ctl[6]  = cw_mem;
    exp_ctl[7]  = cw(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 1'b0);
    exp_ctl[8]  = 17'd0;
    exp_ctl[9]  = 17'd0;
    exp_ctl[10] = CW_FETCH;
    begin_b(16'h2000);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (b_st !== exp_st[i] || ctl_b !== exp_ctl[i]) begin
        n_bad++;
        $display("FAIL sw_wait c%0d: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i + 1, b_st, ctl_b, exp_st[i], exp_ctl[i]);
      end
      if (i == 8) begin
        n_cmp++;
        if (b_count !== 16'd1) begin
          n_bad++;
          $display("FAIL sw_wait_retire: cnt=%0d, want 1 after 8 cycles", b_count);
        end
      end
    end
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_branch_jal();
    logic [2:0]  exp_st[10];
    logic [16:0] exp_ctl[10];
    exp_st = '{ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH, ST_DECODE,
               ST_EXEC, ST_FETCH, ST_DECODE, ST_EXEC, ST_FETCH};
    exp_ctl[0] = CW_FETCH;
    exp_ctl[1] = 17'd0;
    exp_ctl[2] = cw(3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    exp_ctl[3] = CW_FETCH;
    exp_ctl[4] = 17'd0;
    exp_ctl[5] = cw(3'd4, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    exp_ctl[6] = CW_FETCH;
    exp_ctl[7] = 17'd0;
    exp_ctl[8] = cw(3'd1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    exp_ctl[9] = CW_FETCH;
    comp_taken = 1'b0;
    begin_a(16'h8000);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) comp_taken = 1'b1;
      if (i == 5) inst_a = 16'h6000;
      n_cmp++;
      if (a_st !== exp_st[i] || ctl_a !== exp_ctl[i]) begin
        n_bad++;
        $display("FAIL br_jal c%0d: state=%0d ctl=%h, want state=%0d ctl=%h",
                 i + 1, a_st, ctl_a, exp_st[i], exp_ctl[i]);
      end
    end
    n_cmp++;
    if (a_count !== 16'd3) begin
      n_bad++;
      $display("FAIL br_jal_count: cnt=%0d, want 3", a_count);
    end
    comp_taken = 1'b0;
  endtask

  task automatic test_halt_op();
    begin_a(16'hF000);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_st !== ST_HALT || a_halted !== 1'b1 || a_busy !== 1'b0 || a_count !== 16'd1 ||
        a_error !== 1'b0 || ctl_a !== 17'd0) begin
      n_bad++;
      $display("FAIL halt_op: state=%0d halt=%b busy=%b cnt=%0d err=%b ctl=%h, want 6 1 0 1 0 0",
               a_st, a_halted, a_busy, a_count, a_error, ctl_a);
    end
  endtask

  task automatic test_illegal();
    begin_a(16'hA000);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_st !== ST_EXEC || ctl_a !== 17'd0 || a_error !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_exec: state=%0d ctl=%h err=%b, want 3 0 0", a_st, ctl_a, a_error);
    end
    @(negedge clk);
    n_cmp++;
    if (a_st !== ST_HALT || a_error !== 1'b1 || a_halted !== 1'b1 || a_count !== 16'd0) begin
      n_bad++;
      $display("FAIL illegal_halt: state=%0d err=%b halt=%b cnt=%0d, want 6 1 1 0",
               a_st, a_error, a_halted, a_count);
    end
    inst_a = 16'h0000; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_cmp++;
    if (a_st !== ST_FETCH || a_error !== 1'b1 || a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_restart: state=%0d err=%b busy=%b, want 1 1 1", a_st, a_error, a_busy);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_count !== 16'd1 || a_error !== 1'b1 || a_st !== ST_FETCH) begin
      n_bad++;
      $display("FAIL illegal_sticky: cnt=%0d err=%b state=%0d, want 1 1 1", a_count, a_error, a_st);
    end
  endtask

  task automatic test_reset_mid_store();
    begin_a(16'h0000);
    repeat (2) @(negedge clk);
    inst_a = 16'h2000;  // ALU opcode already latched
    repeat (4) @(negedge clk);
    n_cmp++;
    if (a_st !== ST_MEM || a_mw !== 1'b1 || a_count !== 16'd1) begin
      n_bad++;
      $display("FAIL store_final: state=%0d memwrite=%b cnt=%0d, want 4 1 1", a_st, a_mw, a_count);
    end
    rst_a = 1'b1;
    #1;
    n_cmp++;
    if (a_mw !== 1'b0) begin
      n_bad++;
      $display("FAIL store_reset_gate: memwrite=%b, want 0", a_mw);
    end
    @(negedge clk);
    n_cmp++;
    if (a_st !== ST_IDLE || a_count !== 16'd0 || ctl_a !== 17'd0 || a_busy !== 1'b0 ||
        a_error !== 1'b0) begin
      n_bad++;
      $display("FAIL store_reset_after: state=%0d cnt=%0d ctl=%h busy=%b err=%b, want 0 0 0 0 0",
               a_st, a_count, ctl_a, a_busy, a_error);
    end
    rst_a = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu_loop();
    test_push_pop();
    test_sw_wait();
    test_branch_jal();
    test_halt_op();
    test_illegal();
    test_reset_mid_store();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pcsp_mem_sequencer.md
Name: pcsp_mem_sequencer

Overview:
Multicycle control FSM that sequences the PC/SP/memory datapath block. It fetches instructions, decodes the opcode field, and drives every select and write-enable of that block: PCSrc, SPSrc, MemSrc, MemDst, PCWrite, SPWrite, InstWrite and MemWrite. It inserts parameterised memory wait states, provides a run/halt handshake, and counts retired instructions. It sits beside the PC/SP/memory block, between it and the register file.

Parameters:
MEM_WAIT, 0, extra wait cycles per memory access (0..7); the access cycle is repeated MEM_WAIT times before its final cycle.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; sampled on the rising edge of clock
start  in  1  leaves IDLE/HALT and begins fetching at the current PC
inst  in  16  instruction register contents (Inst_out); opcode = inst[15:12]
comp_taken  in  1  branch condition from the comparator; sampled in EXEC
PCSrc  out  3  0=PC+2, 1=ze_imm, 2=RA, 3=Mary, 4=Comp
SPSrc  out  3  0=hold, 1=SP-2, 2=SP+2
SPWrite  out  1  SP register enable
PCWrite  out  1  PC register enable
InstWrite  out  1  instruction register enable
MemWrite  out  1  memory write strobe
MemSrc  out  2  address select: 0=PC, 1=SP, 2=ze_imm, 3=ls_imm
MemDst  out  3  write-data select: 0=Mary, 1=Shelley, 2=RA
RegWrite  out  1  register-file write of MemVal (load/pop writeback)
LinkWrite  out  1  writes PC into RA (JAL)
busy  out  1  high whenever state is not IDLE or HALT
halted  out  1  high in HALT
error  out  1  sticky; set on an illegal opcode, cleared only by reset
instr_count  out  CNT_W  instructions retired; wraps modulo 2^CNT_W

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- Reset: state=IDLE, wait counter=0, instr_count=0, error=0. All enables are 0 and all selects are 0.
- Reset has priority over every other input, including mid-access. A MemWrite that would fall in the reset cycle is suppressed.
- Enables and selects are combinational from the state plus the registered opcode. They are 0 in any state where they are not listed below.
- IDLE/HALT: start=1 -> FETCH. Otherwise hold.
- FETCH: MemSrc=0. Stays in FETCH for MEM_WAIT cycles. On the final cycle: InstWrite=1, PCWrite=1, PCSrc=0; next state is DECODE.
- DECODE: latch opcode = inst[15:12]; next state is EXEC.
- EXEC, by opcode:
  - 0 ALU: retire; next state FETCH.
  - 1 LW and 2 SW: next state MEM.
  - 3 PUSH: SPWrite=1, SPSrc=1; next state MEM.
  - 4 POP: next state MEM.
  - 5 J: PCWrite=1, PCSrc=1; retire.
  - 6 JAL: LinkWrite=1, PCWrite=1, PCSrc=1; retire.
  - 7 JR: PCWrite=1, PCSrc=2; retire.
  - 8 BR: PCWrite=comp_taken, PCSrc=4; retire.
  - 15 HALT: retire; next state HALT.
  - 9..14: error=1; next state HALT; not retired.
- MEM: address select is LW=2, SW=3, PUSH=1, POP=1. Stays in MEM for MEM_WAIT cycles.
  - SW: MemDst=0. PUSH: MemDst=1.
  - SW and PUSH: MemWrite=1 on the final cycle only (exactly one pulse per store); retire; next state FETCH.
  - LW and POP: next state WB.
- WB: RegWrite=1. POP additionally drives SPWrite=1, SPSrc=2. Retire; next state FETCH.
- Retire: instr_count increments by 1 in the same cycle as the transition out of the retiring state.
- Latency with W=MEM_WAIT:
  - ALU, jumps, BR: 3+W cycles.
  - SW, PUSH: 4+2W cycles.
  - LW, POP: 5+2W cycles.
- start is ignored while busy=1.
- Wait counter: reloads to 0 on entry to FETCH and MEM. It never exceeds MEM_WAIT.

Test Plan:
- Reset then start, MEM_WAIT=0, inst=0x0000 held: FETCH/DECODE/EXEC repeat every 3 cycles. PCWrite pulses once per 3 cycles with PCSrc=0. instr_count=3 after 9 cycles.
- PUSH (inst=0x3000): EXEC drives SPWrite=1, SPSrc=1. The next cycle drives MemSrc=1, MemDst=1, MemWrite=1 for exactly 1 cycle. POP (0x4000) then gives RegWrite=1 plus SPWrite=1, SPSrc=2 in WB.
- MEM_WAIT=2, SW (0x2000): FETCH lasts 3 cycles with InstWrite only on the 3rd. MEM lasts 3 cycles with MemSrc=3 and MemWrite only on the 3rd. Total 8 cycles per instruction.
- BR (0x8000) with comp_taken=0 -> PCWrite=0 in EXEC. With comp_taken=1 -> PCWrite=1, PCSrc=4. JAL (0x6000) -> LinkWrite=1, PCSrc=1.
- Illegal opcode 0xA000 -> error=1, halted=1, instr_count unchanged. start re-fetches but error stays 1 until reset.
- Assert reset during the final MEM cycle of a SW -> MemWrite=0 that cycle. Next cycle state=IDLE, instr_count=0, all outputs 0.
